tone_detector: RTL

TONE_DETECTOR -- requirements
Module: tone_detector

---
 rtl/tone_detector.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tone_detector.sv
// Peak-bin tone detector fed by a streaming 128-point FFT.
// Optional magnitude threshold: define TONE_DETECTOR_THRESH_EN.
module tone_detector
`ifdef TONE_DETECTOR_THRESH_EN
#(
  parameter logic [8:0] THRESH = 9'd32
)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce,
  input  logic        sync,
  input  logic [15:0] result,
  output logic        done,
  output logic [15:0] tone
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t     state;
  logic [6:0] bin_cnt;
  logic       drain;
  logic       pv;
  logic [8:0] mag_q;
  logic [6:0] idx_q;
  logic       fin;
  logic [8:0] peak_mag;
  logic [6:0] peak_idx;

  logic [7:0] re;
  logic [7:0] im;
  logic [7:0] abs_re;
  logic [7:0] abs_im;
  logic [8:0] mag;
  logic       start;
  logic       cand;
  logic [15:0] tone_nxt;

  // -128 negates to 8'h80, which read unsigned is 128
  assign re     = result[15:8];
  assign im     = result[7:0];
  assign abs_re = re[7] ? (~re + 8'd1) : re;
  assign abs_im = im[7] ? (~im + 8'd1) : im;
  assign mag    = {1'b0, abs_re} + {1'b0, abs_im};
  assign start  = ce && sync;

  // Candidates are bins 1..63 only
  assign cand = pv && (idx_q != 7'd0) && !idx_q[6]
             && (mag_q > peak_mag);

`ifdef TONE_DETECTOR_THRESH_EN
  assign tone_nxt = (peak_mag < THRESH) ? 16'hFFFF
                  : {9'd0, peak_idx};
`else
  assign tone_nxt = {9'd0, peak_idx};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      bin_cnt  <= 7'd0;
      drain    <= 1'b0;
      pv       <= 1'b0;
      mag_q    <= 9'd0;
      idx_q    <= 7'd0;
      fin      <= 1'b0;
      peak_mag <= 9'd0;
      peak_idx <= 7'd0;
      done     <= 1'b0;
      tone     <= 16'h0000;
    end else begin
      pv <= 1'b0;
      if (cand) begin
        peak_mag <= mag_q;
        peak_idx <= idx_q;
      end
      if (pv && idx_q == 7'd127)
        fin <= 1'b1;
      if (start) begin
        state    <= ACCUM;
        bin_cnt  <= 7'd1;
        drain    <= 1'b0;
        fin      <= 1'b0;
        peak_mag <= 9'd0;
        peak_idx <= 7'd1;
        done     <= 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            if (ce && !drain) begin
              mag_q   <= mag;
              idx_q   <= bin_cnt;
              pv      <= 1'b1;
              bin_cnt <= bin_cnt + 7'd1;
              if (bin_cnt == 7'd127)
                drain <= 1'b1;
            end
            // Last bin has cleared the compare stage
            if (fin) begin
              fin   <= 1'b0;
              drain <= 1'b0;
              if (enable) begin
                state <= DONE;
                done  <= 1'b1;
                tone  <= tone_nxt;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
